// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format constants, opcodes and the
// instruction-memory controller state type.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 5;
    localparam int INSTR_WIDTH  = 32;

    // Opcode field sits in the top OPCODE_WIDTH bits of every instruction.
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD = 5'd8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMP = 5'd16;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 5'd18;

    // Instruction-memory controller states.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } imem_state_e;

    // Build an instruction word carrying only an opcode (all operands zero).
    function automatic logic [INSTR_WIDTH-1:0] opcode_only(input logic [OPCODE_WIDTH-1:0] op);
        return {op, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};
    endfunction

    // Word handed back on a faulting fetch: a HALT, so a runaway PC stops the core.
    localparam logic [INSTR_WIDTH-1:0] DEFAULT_FILL_WORD = {OP_HALT, 27'd0};

endpackage

// File: rtl/imem_ram_1r1w.sv
// Simple dual-port memory array: one synchronous write port, one read port
// with a registered output. No reset on the array or the read register so
// the whole thing maps onto block RAM.
module imem_ram_1r1w #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: store a word when enabled.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: registered read, holds its value when not enabled.
    always_ff @(posedge clock) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_memory_loadable.sv
// Runtime-loadable instruction memory. Program words arrive over a
// valid/ready load port; fetches are accepted one per cycle in RUN and
// answered one cycle later, with addresses at or beyond the loaded program
// length returning FILL_WORD and raising instr_fault.
module instruction_memory_loadable
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(DEFAULT_FILL_WORD)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_ready,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instrucao,
    output logic                  instr_fault,
    output logic [ADDR_WIDTH:0]   prog_length,
    output logic                  mem_loaded
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   ONE_LEN  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    imem_state_e           state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH:0]   prog_length_q;
    logic                  instr_valid_q;
    logic                  instr_fault_q;
    logic                  have_rsp_q;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic load_hs;
    logic load_wr;
    logic fetch_accept;
    logic addr_in_range;

    // Handshake/port qualifiers decoded from the current state.
    assign load_ready    = (state_q == LOAD);
    assign fetch_ready   = (state_q == RUN);
    assign mem_loaded    = (state_q == RUN);
    assign load_hs       = load_valid & load_ready;
    // A restart in the same cycle as a handshake discards that word.
    assign load_wr       = load_hs & ~load_start;
    assign fetch_accept  = fetch_req & fetch_ready;
    // Full 32-bit compare so addresses that alias in the low bits still fault.
    assign addr_in_range = (fetch_addr < 32'(prog_length_q));

    // Controller FSM: load sequencing, word counter and program length.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= EMPTY;
            cnt_q         <= '0;
            prog_length_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        cnt_q <= '0;
                    end else if (load_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        // Filling the last slot ends the load even without load_last.
                        if (load_last || (cnt_q == LAST_IDX)) begin
                            state_q       <= RUN;
                            prog_length_q <= {1'b0, cnt_q} + ONE_LEN;
                        end
                    end
                end
                RUN: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Fetch response pipeline: valid pulse and fault flag one cycle after accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_valid_q <= 1'b0;
            instr_fault_q <= 1'b0;
            have_rsp_q    <= 1'b0;
        end else begin
            instr_valid_q <= fetch_accept;
            if (fetch_accept) begin
                instr_fault_q <= ~addr_in_range;
                have_rsp_q    <= 1'b1;
            end
        end
    end

    imem_ram_1r1w #(
        .WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (load_wr),
        .wr_addr_i (cnt_q),
        .wr_data_i (load_data),
        .rd_en_i   (fetch_accept),
        .rd_addr_i (fetch_addr[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rdata)
    );

    assign prog_length = prog_length_q;
    assign instr_valid = instr_valid_q;
    assign instr_fault = instr_fault_q;
    // The RAM read register is not reset, so gate it until a fetch has completed.
    assign instrucao   = !have_rsp_q    ? '0 :
                         instr_fault_q ? FILL_WORD : ram_rdata;

endmodule
